// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the frame checker and the stream generator.
// Holds the default polynomial, the per-byte CRC update and the FSM states.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        S_LEN = 2'd0,
        S_PAY = 2'd1,
        S_CRC = 2'd2
    } state_t;

    // MSB-first byte update: fold the byte into the register, then
    // run eight shift/xor steps.
    function automatic logic [7:0] crc8_byte(
        input logic [7:0] crc,
        input logic [7:0] data,
        input logic [7:0] poly
    );
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ poly;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/byte_out_reg.sv
// Single valid/ready register stage carrying a payload byte and its last flag.
// Ports: clk, rst_n (sync, active-low), i_load/i_data/i_last load side,
// o_can_load (room for a load this cycle), o_valid/o_data/o_last/i_ready out.
module byte_out_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_can_load,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_ready
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    // A load may coincide with a transfer out, so the stage sustains
    // one byte per cycle while downstream is ready.
    assign o_can_load = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 checker for [LEN][payload][CRC] frames; forwards payload
// through a register stage and reports pass/fail per frame.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data byte input;
// out_valid/out_ready/out_data/out_last payload output; frame_done pulse,
// frame_ok held result, err_count saturating fail count, busy mid-frame.
// Optional: define CRC8_CHK_TIMEOUT_EN to abort frames idle for TIMEOUT cycles.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0]  POLY    = CRC8_POLY,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_crc;
    logic [7:0]       r_rem;
    logic             r_done;
    logic             r_ok;
    logic [CNT_W-1:0] r_err;

    logic w_acc;
    logic w_load;
    logic w_can_load;
    logic w_tmo;

    assign w_acc = in_valid && in_ready;

`ifdef CRC8_CHK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle;

    assign w_tmo = busy && (r_idle == IDLE_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!busy || w_acc || w_tmo) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    // No idle timer: a stalled frame waits for its next byte forever.
    assign w_tmo = 1'b0 && (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = S_LEN;
        end else begin
            unique case (1'b1)
                (r_state == S_LEN): begin
                    if (w_acc) begin
                        w_next = (in_data == 8'h00) ? S_CRC : S_PAY;
                    end
                end
                (r_state == S_PAY): begin
                    if (w_acc && r_rem == 8'd1) begin
                        w_next = S_CRC;
                    end
                end
                (r_state == S_CRC): begin
                    if (w_acc) begin
                        w_next = S_LEN;
                    end
                end
                default: w_next = S_LEN;
            endcase
        end
    end

    // Only payload bytes wait on the output stage; LEN and CRC always flow.
    // The abort cycle refuses input so no byte is silently swallowed.
    always_comb begin
        in_ready = 1'b1;
        busy     = (r_state != S_LEN);
        w_load   = 1'b0;
        if (r_state == S_PAY) begin
            in_ready = w_can_load;
            w_load   = in_valid && w_can_load && !w_tmo;
        end
        if (w_tmo) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc  <= 8'h00;
            r_rem  <= 8'h00;
            r_done <= 1'b0;
            r_ok   <= 1'b0;
            r_err  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_tmo) begin
                r_crc  <= 8'h00;
                r_rem  <= 8'h00;
                r_done <= 1'b1;
                r_ok   <= 1'b0;
                if (r_err != '1) begin
                    r_err <= r_err + 1'b1;
                end
            end else if (w_acc) begin
                unique case (1'b1)
                    (r_state == S_LEN): begin
                        r_crc <= crc8_byte(8'h00, in_data, POLY);
                        r_rem <= in_data;
                    end
                    (r_state == S_PAY): begin
                        r_crc <= crc8_byte(r_crc, in_data, POLY);
                        r_rem <= r_rem - 1'b1;
                    end
                    (r_state == S_CRC): begin
                        r_ok   <= (in_data == r_crc);
                        r_done <= 1'b1;
                        r_crc  <= 8'h00;
                        if (in_data != r_crc && r_err != '1) begin
                            r_err <= r_err + 1'b1;
                        end
                    end
                    default: begin
                        r_crc <= 8'h00;
                        r_rem <= 8'h00;
                    end
                endcase
            end
        end
    end

    byte_out_reg u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_data     (in_data),
        .i_last     (r_rem == 8'd1),
        .o_can_load (w_can_load),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_last     (out_last),
        .i_ready    (out_ready)
    );

    assign frame_done = r_done;
    assign frame_ok   = r_ok;
    assign err_count  = r_err;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: hand-built frames, a bit-serial
// reference CRC and a payload collector.
module tb_crc8_frame_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       frame_ok;
    logic [7:0] err_count;
    logic       busy;

    crc8_frame_checker #(
        .POLY    (8'h07),
        .CNT_W   (8),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial LFSR reference, one data bit at a time.
    function automatic logic [7:0] ref_crc(input logic [7:0] c,
                                           input logic [7:0] d);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    logic [7:0] got_d[$];
    bit         got_l[$];
    int         done_cnt = 0;
    logic       last_ok = 1'b0;
    logic [7:0] pay[$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (rst_n && frame_done) begin
            done_cnt++;
            last_ok = frame_ok;
        end
    end

    task automatic clr();
        got_d.delete();
        got_l.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("send_stall", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] crcx,
                             input bit exp_ok);
        logic [7:0] c;
        int         d0;
        int         n;
        d0 = done_cnt;
        n  = pay.size();
        clr();
        c = ref_crc(8'h00, 8'(n));
        send_byte(8'(n));
        foreach (pay[i]) begin
            c = ref_crc(c, pay[i]);
            send_byte(pay[i]);
        end
        send_byte(c ^ crcx);
        repeat (3) @(negedge clk);
        chk({tag, "_n"}, got_d.size(), n);
        if (got_d.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_d"}, got_d[i], pay[i]);
                chk({tag, "_l"}, got_l[i], (i == n - 1));
            end
        end
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_ok"}, last_ok, exp_ok);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        int         d0;
        int         w;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 01 00 15: check one-cycle payload and result latency.
        clr();
        send_byte(8'h01);
        chk("t1_busy", busy, 1);
        send_byte(8'h00);
        chk("t1_ov", out_valid, 1);
        chk("t1_od", out_data, 8'h00);
        chk("t1_ol", out_last, 1);
        send_byte(8'h15);
        chk("t1_done", frame_done, 1);
        chk("t1_ok", frame_ok, 1);
        chk("t1_err", err_count, 0);
        chk("t1_busy0", busy, 0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", frame_done, 0);
        chk("t1_ok_held", frame_ok, 1);
        chk("t1_n", got_d.size(), 1);

        // "123456789", good then corrupted CRC.
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};
        run_frame("t2a", 8'h00, 1'b1);
        chk("t2a_err", err_count, 0);
        run_frame("t2b", 8'h01, 1'b0);
        chk("t2b_err", err_count, 1);

        // Empty frames.
        pay.delete();
        run_frame("t3a", 8'h00, 1'b1);
        chk("t3a_err", err_count, 1);
        @(negedge clk);
        clr();
        d0 = done_cnt;
        send_byte(8'h00);
        send_byte(8'h5A);
        repeat (3) @(negedge clk);
        chk("t3b_n", got_d.size(), 0);
        chk("t3b_done", done_cnt - d0, 1);
        chk("t3b_ok", last_ok, 0);
        chk("t3b_err", err_count, 2);

        // Backpressure: out_ready low for 5 cycles after first payload byte.
        clr();
        d0 = done_cnt;
        out_ready = 1'b0;
        c = ref_crc(8'h00, 8'h03);
        send_byte(8'h03);
        c = ref_crc(c, 8'hAA);
        send_byte(8'hAA);
        chk("t4_in_ready", in_ready, 0);
        repeat (5) @(negedge clk);
        chk("t4_hold_d", out_data, 8'hAA);
        chk("t4_hold_v", out_valid, 1);
        out_ready = 1'b1;
        c = ref_crc(c, 8'hBB);
        send_byte(8'hBB);
        c = ref_crc(c, 8'hCC);
        send_byte(8'hCC);
        send_byte(c);
        repeat (3) @(negedge clk);
        chk("t4_n", got_d.size(), 3);
        if (got_d.size() == 3) begin
            chk("t4_d0", got_d[0], 8'hAA);
            chk("t4_d1", got_d[1], 8'hBB);
            chk("t4_d2", got_d[2], 8'hCC);
            chk("t4_l", {got_l[0], got_l[1], got_l[2]}, 3'b001);
        end
        chk("t4_done", done_cnt - d0, 1);
        chk("t4_ok", last_ok, 1);
        chk("t4_err", err_count, 2);

        // Reset mid-frame.
        clr();
        d0 = done_cnt;
        send_byte(8'h02);
        send_byte(8'h11);
        chk("t5_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_in_ready", in_ready, 1);
        chk("t5_ov", out_valid, 0);
        chk("t5_od", out_data, 0);
        chk("t5_ol", out_last, 0);
        chk("t5_done", frame_done, 0);
        chk("t5_ok", frame_ok, 0);
        chk("t5_err", err_count, 0);
        chk("t5_busy0", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_nodone", done_cnt - d0, 0);
        pay = '{8'h00};
        run_frame("t5b", 8'h00, 1'b1);
        chk("t5b_err", err_count, 0);

`ifdef CRC8_CHK_TIMEOUT_EN
        // Stalled frame aborts after TIMEOUT idle cycles.
        clr();
        d0 = done_cnt;
        send_byte(8'h02);
        send_byte(8'h11);
        w = 0;
        while (done_cnt == d0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_ok", last_ok, 0);
        chk("t6_err", err_count, 1);
        chk("t6_busy", busy, 0);
        pay = '{8'h00};
        run_frame("t6b", 8'h00, 1'b1);
        chk("t6b_err", err_count, 1);
`else
        w = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
